// File: rtl/branch_resolve_pred.sv
// rtl/branch_resolve_pred.sv - execute-stage branch resolution with bimodal PHT; BR_PRED_STAT_EN adds statistics counters
module branch_resolve_pred #(
  parameter int DATA_W    = 32,
  parameter int PC_W      = 32,
  parameter int PHT_DEPTH = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [PC_W-1:0]   lookup_pc,
  output logic              lookup_taken,
  input  logic              in_valid,
  input  logic [PC_W-1:0]   in_pc,
  input  logic              in_pred_taken,
  input  logic              op_bltz,
  input  logic              op_bgez,
  input  logic              op_beq,
  input  logic              op_bne,
  input  logic              op_blez,
  input  logic              op_bgtz,
  input  logic [DATA_W-1:0] rega,
  input  logic [DATA_W-1:0] regb,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic              out_taken,
  output logic              out_mispredict,
  output logic [31:0]       stat_branches,
  output logic [31:0]       stat_mispredicts
);

  localparam int IDX_W = $clog2(PHT_DEPTH);

  logic [1:0]        pht_q [PHT_DEPTH];
  logic [1:0]        cnt_q;
  logic [1:0]        cnt_d;
  logic [IDX_W-1:0]  wr_idx;
  logic [IDX_W-1:0]  rd_idx;
  logic              eq;
  logic              lez;
  logic              taken;
  logic              mispredict;
  logic              is_branch;
  logic              accept;

  logic              out_valid_q;
  logic [PC_W-1:0]   out_pc_q;
  logic              out_taken_q;
  logic              out_mispredict_q;

  // Only the index bits of the lookup PC select a counter; the rest are don't-care.
  logic              unused_lookup_bits;
  assign unused_lookup_bits = ^lookup_pc;

  assign rd_idx       = lookup_pc[IDX_W+1:2];
  assign wr_idx       = in_pc[IDX_W+1:2];
  assign lookup_taken = pht_q[rd_idx][1];

  // Branch condition evaluation; illegal multi-hot ops simply OR their terms.
  always_comb begin
    eq    = (rega == regb);
    lez   = rega[DATA_W-1] | (rega == '0);
    taken = (op_beq  &  eq)
          | (op_bne  & ~eq)
          | (op_blez &  lez)
          | (op_bgtz & ~lez)
          | (op_bltz &  rega[DATA_W-1])
          | (op_bgez & ~rega[DATA_W-1]);
    mispredict = taken ^ in_pred_taken;
    is_branch  = in_valid & (op_bltz | op_bgez | op_beq | op_bne | op_blez | op_bgtz);
    accept     = is_branch & ~stall & ~flush;
  end

  // Saturating 2-bit counter step for the entry being trained.
  always_comb begin
    cnt_q = pht_q[wr_idx];
    cnt_d = cnt_q;
    if (taken) begin
      if (cnt_q != 2'd3) cnt_d = cnt_q + 2'd1;
    end else begin
      if (cnt_q != 2'd0) cnt_d = cnt_q - 2'd1;
    end
  end

  // PHT: whole table returns to weak not-taken in one reset cycle; trained only by accepted branches.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= 2'd1;
    end else if (accept) begin
      pht_q[wr_idx] <= cnt_d;
    end
  end

  // Result register: flush beats stall, stall freezes everything, otherwise load every cycle.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_valid_q      <= 1'b0;
      out_pc_q         <= '0;
      out_taken_q      <= 1'b0;
      out_mispredict_q <= 1'b0;
    end else if (flush) begin
      out_valid_q      <= 1'b0;
    end else if (!stall) begin
      out_valid_q      <= is_branch;
      out_pc_q         <= in_pc;
      out_taken_q      <= taken;
      out_mispredict_q <= mispredict;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_pc         = out_pc_q;
  assign out_taken      = out_taken_q;
  assign out_mispredict = out_mispredict_q;

`ifdef BR_PRED_STAT_EN
  logic [31:0] stat_branches_q;
  logic [31:0] stat_mispredicts_q;

  // Statistics count accepted branches only; both wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else if (accept) begin
      stat_branches_q <= stat_branches_q + 32'd1;
      if (mispredict) stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_pred.sv
// tb/tb_branch_resolve_pred.sv - directed-vector bench for branch_resolve_pred
module tb_branch_resolve_pred;

  localparam logic [5:0] BLTZ = 6'b100000;
  localparam logic [5:0] BGEZ = 6'b010000;
  localparam logic [5:0] BEQ  = 6'b001000;
  localparam logic [5:0] BNE  = 6'b000100;
  localparam logic [5:0] BLEZ = 6'b000010;
  localparam logic [5:0] BGTZ = 6'b000001;

  logic        clk;
  logic        resetn;
  logic [31:0] lookup_pc;
  logic        lookup_taken;
  logic        in_valid;
  logic [31:0] in_pc;
  logic        in_pred_taken;
  logic [5:0]  op;
  logic [31:0] rega, regb;
  logic        stall, flush;
  logic        out_valid;
  logic [31:0] out_pc;
  logic        out_taken, out_mispredict;
  logic [31:0] stat_branches, stat_mispredicts;

  logic [31:0] w_lookup_pc;
  logic        w_lookup_taken;
  logic        w_valid;
  logic [31:0] w_pc;
  logic        w_pred;
  logic [5:0]  w_op;
  logic [7:0]  w_rega, w_regb;
  logic        w_stall, w_flush;
  logic        w_out_valid;
  logic [31:0] w_out_pc;
  logic        w_out_taken, w_out_mispredict;
  logic [31:0] w_stat_b, w_stat_m;

  int n_vec;
  int n_err;
  int exp_br;
  int exp_mp;

  branch_resolve_pred dut (
    .clk(clk), .resetn(resetn),
    .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
    .in_valid(in_valid), .in_pc(in_pc), .in_pred_taken(in_pred_taken),
    .op_bltz(op[5]), .op_bgez(op[4]), .op_beq(op[3]), .op_bne(op[2]),
    .op_blez(op[1]), .op_bgtz(op[0]),
    .rega(rega), .regb(regb), .stall(stall), .flush(flush),
    .out_valid(out_valid), .out_pc(out_pc), .out_taken(out_taken),
    .out_mispredict(out_mispredict),
    .stat_branches(stat_branches), .stat_mispredicts(stat_mispredicts)
  );

  branch_resolve_pred #(.DATA_W(8), .PC_W(32), .PHT_DEPTH(2)) dut8 (
    .clk(clk), .resetn(resetn),
    .lookup_pc(w_lookup_pc), .lookup_taken(w_lookup_taken),
    .in_valid(w_valid), .in_pc(w_pc), .in_pred_taken(w_pred),
    .op_bltz(w_op[5]), .op_bgez(w_op[4]), .op_beq(w_op[3]), .op_bne(w_op[2]),
    .op_blez(w_op[1]), .op_bgtz(w_op[0]),
    .rega(w_rega), .regb(w_regb), .stall(w_stall), .flush(w_flush),
    .out_valid(w_out_valid), .out_pc(w_out_pc), .out_taken(w_out_taken),
    .out_mispredict(w_out_mispredict),
    .stat_branches(w_stat_b), .stat_mispredicts(w_stat_m)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one request for one edge; the bench tracks accepted branches for the stat model.
  task automatic drive(input logic [5:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] pc, input logic pred, input logic exp_t,
                       input logic stl, input logic fl);
    op = o; rega = a; regb = b; in_pc = pc; in_pred_taken = pred;
    in_valid = 1'b1; stall = stl; flush = fl;
    @(posedge clk); #1;
    if (o != 6'd0 && !stl && !fl) begin
      exp_br++;
      if (exp_t != pred) exp_mp++;
    end
    in_valid = 1'b0; op = 6'd0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    exp_br = 0;
    exp_mp = 0;
  endtask

  task automatic test_reset();
    do_reset();
    lookup_pc = 32'h100; #1;
    n_vec++; if (lookup_taken !== 1'b0) begin n_err++; $display("FAIL reset_lookup got=%0b exp=0", lookup_taken); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL reset_out_pc got=%h exp=0", out_pc); end
    n_vec++; if (stat_branches !== 32'h0) begin n_err++; $display("FAIL reset_stat_branches got=%0d exp=0", stat_branches); end
  endtask

  task automatic test_beq();
    drive(BEQ, 32'h1234, 32'h1234, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beq_valid got=%0b exp=1", out_valid); end
    n_vec++; if (out_taken !== 1'b1) begin n_err++; $display("FAIL beq_taken got=%0b exp=1", out_taken); end
    n_vec++; if (out_mispredict !== 1'b1) begin n_err++; $display("FAIL beq_mispredict got=%0b exp=1", out_mispredict); end
    n_vec++; if (out_pc !== 32'h40) begin n_err++; $display("FAIL beq_pc got=%h exp=40", out_pc); end
    lookup_pc = 32'h40; #1;
    n_vec++; if (lookup_taken !== 1'b1) begin n_err++; $display("FAIL beq_lookup got=%0b exp=1", lookup_taken); end
  endtask

  task automatic test_conditions();
    logic [5:0]  ops [10] = '{BLEZ, BGTZ, BLTZ, BGEZ, BLEZ, BGTZ, BNE, BEQ, BGEZ, BLTZ};
    logic [31:0] as  [10] = '{32'h0, 32'h0, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                              32'h1, 32'h5, 32'h5, 32'h0, 32'h7fff_ffff};
    logic [31:0] bs  [10] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h6, 32'h6, 32'h0, 32'h0};
    logic        ex  [10] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      drive(ops[i], as[i], bs[i], 32'h104 + 32'(4 * i), 1'b1, ex[i], 1'b0, 1'b0);
      n_vec++; if (out_taken !== ex[i]) begin n_err++; $display("FAIL cond%0d_taken got=%0b exp=%0b", i, out_taken, ex[i]); end
      n_vec++; if (out_mispredict !== !ex[i]) begin n_err++; $display("FAIL cond%0d_mispredict got=%0b exp=%0b", i, out_mispredict, !ex[i]); end
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL cond%0d_valid got=%0b exp=1", i, out_valid); end
    end
  endtask

  task automatic test_saturation();
    logic exp_l [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(BEQ, 32'h9, 32'h9, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);
      else       drive(BNE, 32'h9, 32'h9, 32'h80, 1'b1, 1'b0, 1'b0, 1'b0);
      lookup_pc = 32'h80; #1;
      n_vec++; if (lookup_taken !== exp_l[i]) begin n_err++; $display("FAIL sat%0d_lookup got=%0b exp=%0b", i, lookup_taken, exp_l[i]); end
    end
    n_vec++; if (out_mispredict !== 1'b1) begin n_err++; $display("FAIL sat_mispredict got=%0b exp=1", out_mispredict); end
  endtask

  task automatic test_hazards();
    drive(BNE, 32'h7, 32'h7, 32'h40, 1'b0, 1'b0, 1'b1, 1'b0);
    lookup_pc = 32'h40; #1;
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid got=%0b exp=1", out_valid); end
    n_vec++; if (out_pc !== 32'h80) begin n_err++; $display("FAIL stall_pc got=%h exp=80", out_pc); end
    n_vec++; if (out_mispredict !== 1'b1) begin n_err++; $display("FAIL stall_mispredict got=%0b exp=1", out_mispredict); end
    n_vec++; if (lookup_taken !== 1'b1) begin n_err++; $display("FAIL stall_pht got=%0b exp=1", lookup_taken); end
    drive(BNE, 32'h7, 32'h7, 32'h40, 1'b0, 1'b0, 1'b1, 1'b1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_stall_valid got=%0b exp=0", out_valid); end
    n_vec++; if (lookup_taken !== 1'b1) begin n_err++; $display("FAIL flush_stall_pht got=%0b exp=1", lookup_taken); end
    drive(BEQ, 32'h1, 32'h1, 32'h84, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(BEQ, 32'h1, 32'h1, 32'h84, 1'b0, 1'b1, 1'b0, 1'b1);
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid got=%0b exp=0", out_valid); end
  endtask

  task automatic test_nonbranch();
    drive(6'd0, 32'h3, 32'h4, 32'h40, 1'b0, 1'b0, 1'b0, 1'b0);
    lookup_pc = 32'h40; #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL nonbranch_valid got=%0b exp=0", out_valid); end
    n_vec++; if (lookup_taken !== 1'b1) begin n_err++; $display("FAIL nonbranch_pht got=%0b exp=1", lookup_taken); end
  endtask

  task automatic test_back_to_back();
    drive(BEQ, 32'h2, 32'h2, 32'h140, 1'b0, 1'b1, 1'b0, 1'b0);
    n_vec++; if (out_pc !== 32'h140 || out_taken !== 1'b1 || out_mispredict !== 1'b1)
      begin n_err++; $display("FAIL b2b_first got=%h/%0b/%0b exp=140/1/1", out_pc, out_taken, out_mispredict); end
    drive(BNE, 32'h2, 32'h2, 32'h144, 1'b0, 1'b0, 1'b0, 1'b0);
    n_vec++; if (out_pc !== 32'h144 || out_taken !== 1'b0 || out_mispredict !== 1'b0 || out_valid !== 1'b1)
      begin n_err++; $display("FAIL b2b_second got=%h/%0b/%0b exp=144/0/0", out_pc, out_taken, out_mispredict); end
  endtask

  task automatic test_stats();
    int eb, em;
`ifdef BR_PRED_STAT_EN
    eb = exp_br; em = exp_mp;
`else
    eb = 0; em = 0;
`endif
    n_vec++; if (stat_branches !== 32'(eb)) begin n_err++; $display("FAIL stat_branches got=%0d exp=%0d", stat_branches, eb); end
    n_vec++; if (stat_mispredicts !== 32'(em)) begin n_err++; $display("FAIL stat_mispredicts got=%0d exp=%0d", stat_mispredicts, em); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    lookup_pc = 32'h80; #1;
    n_vec++; if (lookup_taken !== 1'b0) begin n_err++; $display("FAIL midreset_lookup got=%0b exp=0", lookup_taken); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL midreset_valid got=%0b exp=0", out_valid); end
    n_vec++; if (stat_branches !== 32'h0) begin n_err++; $display("FAIL midreset_stat got=%0d exp=0", stat_branches); end
  endtask

  task automatic test_wrap();
    w_lookup_pc = 32'h8; #1;
    n_vec++; if (w_lookup_taken !== 1'b0) begin n_err++; $display("FAIL wrap_pre got=%0b exp=0", w_lookup_taken); end
    for (int i = 0; i < 2; i++) begin
      w_op = BEQ; w_rega = 8'h3; w_regb = 8'h3; w_pc = 32'h0; w_pred = 1'b0; w_valid = 1'b1;
      @(posedge clk); #1;
      w_valid = 1'b0; w_op = 6'd0;
    end
    n_vec++; if (w_lookup_taken !== 1'b1) begin n_err++; $display("FAIL wrap_alias got=%0b exp=1", w_lookup_taken); end
    w_lookup_pc = 32'h4; #1;
    n_vec++; if (w_lookup_taken !== 1'b0) begin n_err++; $display("FAIL wrap_other got=%0b exp=0", w_lookup_taken); end
    w_op = BGEZ; w_rega = 8'h80; w_regb = 8'h0; w_pc = 32'h10; w_valid = 1'b1;
    @(posedge clk); #1;
    n_vec++; if (w_out_taken !== 1'b0 || w_out_valid !== 1'b1) begin n_err++; $display("FAIL wrap_bgez got=%0b/%0b exp=0/1", w_out_taken, w_out_valid); end
    w_op = BLTZ;
    @(posedge clk); #1;
    n_vec++; if (w_out_taken !== 1'b1) begin n_err++; $display("FAIL wrap_bltz got=%0b exp=1", w_out_taken); end
    w_valid = 1'b0; w_op = 6'd0;
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_br = 0; exp_mp = 0;
    resetn = 1'b0; lookup_pc = '0; in_valid = 1'b0; in_pc = '0; in_pred_taken = 1'b0;
    op = 6'd0; rega = '0; regb = '0; stall = 1'b0; flush = 1'b0;
    w_lookup_pc = '0; w_valid = 1'b0; w_pc = '0; w_pred = 1'b0; w_op = 6'd0;
    w_rega = '0; w_regb = '0; w_stall = 1'b0; w_flush = 1'b0;
    test_reset();
    test_beq();
    test_conditions();
    test_saturation();
    test_hazards();
    test_nonbranch();
    test_back_to_back();
    test_stats();
    test_wrap();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
